// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of one instruction memory among NUM_CORES fetch stages, fixed MEM_LAT response.
// Define IMEM_ARB_PRIO0_EN to give core 0 fixed top priority over a round-robin among the rest.
module imem_arbiter #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES-1:0]        flush,
  output logic [NUM_CORES-1:0]        gnt,
  output logic                        mem_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [NUM_CORES-1:0]        rvalid,
  output logic [DATA_W-1:0]           rdata
);
  localparam int IDW = $clog2(NUM_CORES);
  logic [IDW-1:0] rr_ptr, gid, j, nxt_ptr;
  logic found, adv;
  logic           pv    [MEM_LAT];
  logic [IDW-1:0] pid   [MEM_LAT];
  logic           in_v  [MEM_LAT];
  logic [IDW-1:0] in_id [MEM_LAT];
  always_comb begin
    found = 1'b0;
    gid = '0;
    j = '0;
`ifdef IMEM_ARB_PRIO0_EN
    found = req[0];
`endif
    for (int k = 0; k < NUM_CORES; k++) begin
      j = IDW'((int'(rr_ptr) + k) % NUM_CORES);
      if (!found && req[j]) begin
        found = 1'b1;
        gid = j;
      end
    end
  end
`ifdef IMEM_ARB_PRIO0_EN
  assign adv = found && gid != '0;
`else
  assign adv = found;
`endif
  assign nxt_ptr  = (gid == IDW'(NUM_CORES - 1)) ? '0 : gid + 1'b1;
  assign gnt      = found ? NUM_CORES'(1) << gid : '0;
  assign mem_en   = found;
  assign mem_addr = found ? addr[int'(gid)*ADDR_W +: ADDR_W] : '0;
  // flush squashes an entry as it moves into the next stage, including a same-cycle grant
  always_comb begin
    in_v[0] = found & ~flush[gid];
    in_id[0] = gid;
    for (int k = 1; k < MEM_LAT; k++) begin
      in_v[k] = pv[k-1] & ~flush[pid[k-1]];
      in_id[k] = pid[k-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rdata <= '0;
      for (int k = 0; k < MEM_LAT; k++) begin
        pv[k] <= 1'b0;
        pid[k] <= '0;
      end
    end else begin
      if (adv) rr_ptr <= nxt_ptr;
      for (int k = 0; k < MEM_LAT; k++) begin
        pv[k] <= in_v[k];
        pid[k] <= in_id[k];
      end
      if (in_v[MEM_LAT-1]) rdata <= mem_rdata;
    end
  end
  assign rvalid = pv[MEM_LAT-1] ? NUM_CORES'(1) << pid[MEM_LAT-1] : '0;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed checks of imem_arbiter with 2 cores at MEM_LAT 1 and 3, and 3 cores at MEM_LAT 1.
module tb_imem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req2 = '0, flush2 = '0;
  logic [63:0] addr2 = {32'h200, 32'h100};
  logic [2:0] req3 = '0, flush3 = '0;
  logic [95:0] addr3 = {32'h3C0, 32'h2C0, 32'h1C0};
  logic [1:0] gnt_a, rv_a, gnt_b, rv_b;
  logic [2:0] gnt_c, rv_c;
  logic en_a, en_b, en_c;
  logic [31:0] ma_a, ma_b, ma_c, md_a, md_b, md_c, rd_a, rd_b, rd_c, a1, a2;
  int errors = 0, checks = 0;
  int ec [8];

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  always #5 clk = ~clk;
  assign md_a = f(ma_a);
  assign md_c = f(ma_c);
  assign md_b = f(a2);
  always @(posedge clk) begin
    a1 <= ma_b;
    a2 <= a1;
  end

  imem_arbiter #(.NUM_CORES(2), .MEM_LAT(1)) ua (.clk(clk), .rst(rst), .req(req2), .addr(addr2), .flush(flush2),
    .gnt(gnt_a), .mem_en(en_a), .mem_addr(ma_a), .mem_rdata(md_a), .rvalid(rv_a), .rdata(rd_a));
  imem_arbiter #(.NUM_CORES(2), .MEM_LAT(3)) ub (.clk(clk), .rst(rst), .req(req2), .addr(addr2), .flush(flush2),
    .gnt(gnt_b), .mem_en(en_b), .mem_addr(ma_b), .mem_rdata(md_b), .rvalid(rv_b), .rdata(rd_b));
  imem_arbiter #(.NUM_CORES(3), .MEM_LAT(1)) uc (.clk(clk), .rst(rst), .req(req3), .addr(addr3), .flush(flush3),
    .gnt(gnt_c), .mem_en(en_c), .mem_addr(ma_c), .mem_rdata(md_c), .rvalid(rv_c), .rdata(rd_c));

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    cyc;
    rst = 1'b1;
    req2 = '0;
    req3 = '0;
    flush2 = '0;
    flush3 = '0;
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (gnt_a !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_a); end
    checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", en_a); end
    checks++; if (ma_a !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", ma_a); end
    checks++; if (rv_a !== 2'b00 || rv_b !== 2'b00 || rv_c !== 3'b000) begin errors++; $display("FAIL reset_rvalid: got %b/%b/%b expected 0", rv_a, rv_b, rv_c); end
    checks++; if (rd_a !== 32'h0 || rd_b !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h expected 0", rd_a, rd_b); end
    cyc;
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_single;
    do_reset;
    cyc; req2 = 2'b01; #4;
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL single_gnt: got %b expected 01", gnt_a); end
    checks++; if (en_a !== 1'b1) begin errors++; $display("FAIL single_mem_en: got %b expected 1", en_a); end
    checks++; if (ma_a !== 32'h100) begin errors++; $display("FAIL single_mem_addr: got %h expected 100", ma_a); end
    cyc; req2 = 2'b00; #4;
    checks++; if (rv_a !== 2'b01) begin errors++; $display("FAIL single_rvalid: got %b expected 01", rv_a); end
    checks++; if (rd_a !== 32'h0100FEFF) begin errors++; $display("FAIL single_rdata: got %h expected 0100feff", rd_a); end
    checks++; if (gnt_a !== 2'b00 || ma_a !== 32'h0) begin errors++; $display("FAIL idle_gnt: got %b/%h expected 00/0", gnt_a, ma_a); end
    for (int k = 0; k < 3; k++) begin
      cyc; req2 = 2'b10; #4;
      checks++; if (gnt_a !== 2'b10) begin errors++; $display("FAIL lone_gnt[%0d]: got %b expected 10", k, gnt_a); end
      if (k > 0) begin
        checks++; if (rv_a !== 2'b10 || rd_a !== 32'h0200FDFF) begin errors++; $display("FAIL lone_resp[%0d]: got %b/%h expected 10/0200fdff", k, rv_a, rd_a); end
      end
    end
    cyc; req2 = 2'b00; #4;
    checks++; if (rv_a !== 2'b10) begin errors++; $display("FAIL lone_last_rvalid: got %b expected 10", rv_a); end
  endtask

  task automatic test_round_robin;
    logic [1:0] e [6];
    for (int k = 0; k < 6; k++)
`ifdef IMEM_ARB_PRIO0_EN
      e[k] = 2'b01;
`else
      e[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
    do_reset;
    for (int k = 0; k < 6; k++) begin
      cyc; req2 = 2'b11; #4;
      checks++; if (gnt_a !== e[k]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", k, gnt_a, e[k]); end
      if (k > 0) begin
        checks++; if (rv_a !== e[k-1] || rd_a !== (e[k-1] == 2'b01 ? 32'h0100FEFF : 32'h0200FDFF)) begin errors++; $display("FAIL rr_resp[%0d]: got %b/%h expected %b", k, rv_a, rd_a, e[k-1]); end
      end
    end
    cyc; req2 = 2'b00; #4;
    checks++; if (rv_a !== e[5]) begin errors++; $display("FAIL rr_last_rvalid: got %b expected %b", rv_a, e[5]); end
  endtask

  task automatic test_latency3;
    do_reset;
    cyc; req2 = 2'b01; #4;
    checks++; if (gnt_b !== 2'b01 || en_b !== 1'b1) begin errors++; $display("FAIL lat3_gnt0: got %b/%b expected 01/1", gnt_b, en_b); end
    cyc; req2 = 2'b10; #4;
    checks++; if (gnt_b !== 2'b10) begin errors++; $display("FAIL lat3_gnt1: got %b expected 10", gnt_b); end
    cyc; req2 = 2'b00; #4;
    checks++; if (rv_b !== 2'b00) begin errors++; $display("FAIL lat3_early: got %b expected 00", rv_b); end
    cyc; #4;
    checks++; if (rv_b !== 2'b01 || rd_b !== 32'h0100FEFF) begin errors++; $display("FAIL lat3_resp0: got %b/%h expected 01/0100feff", rv_b, rd_b); end
    cyc; #4;
    checks++; if (rv_b !== 2'b10 || rd_b !== 32'h0200FDFF) begin errors++; $display("FAIL lat3_resp1: got %b/%h expected 10/0200fdff", rv_b, rd_b); end
    cyc; #4;
    checks++; if (rv_b !== 2'b00 || rd_b !== 32'h0200FDFF) begin errors++; $display("FAIL lat3_hold: got %b/%h expected 00/0200fdff", rv_b, rd_b); end
  endtask

  task automatic test_flush;
    do_reset;
    cyc; req2 = 2'b10; #4;
    checks++; if (gnt_b !== 2'b10) begin errors++; $display("FAIL flush_gnt1: got %b expected 10", gnt_b); end
    cyc; req2 = 2'b01; flush2 = 2'b10; #4;
    checks++; if (gnt_b !== 2'b01) begin errors++; $display("FAIL flush_gnt0: got %b expected 01", gnt_b); end
    cyc; req2 = 2'b00; flush2 = 2'b00; #4;
    checks++; if (rv_b !== 2'b00) begin errors++; $display("FAIL flush_t2: got %b expected 00", rv_b); end
    cyc; #4;
    checks++; if (rv_b !== 2'b00) begin errors++; $display("FAIL flush_squashed: got %b expected 00", rv_b); end
    cyc; #4;
    checks++; if (rv_b !== 2'b01 || rd_b !== 32'h0100FEFF) begin errors++; $display("FAIL flush_survivor: got %b/%h expected 01/0100feff", rv_b, rd_b); end
    cyc; req2 = 2'b01; flush2 = 2'b01; #4;
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL flush_same_gnt: got %b expected 01", gnt_a); end
    cyc; req2 = 2'b00; flush2 = 2'b00; #4;
    checks++; if (rv_a !== 2'b00) begin errors++; $display("FAIL flush_same_rvalid: got %b expected 00", rv_a); end
  endtask

  task automatic test_async_reset;
    do_reset;
    cyc; req2 = 2'b11;
    cyc; req2 = 2'b11;
    cyc; req2 = 2'b00;
    #2 rst = 1'b1;
    #1;
    checks++; if (rv_a !== 2'b00 || rv_b !== 2'b00) begin errors++; $display("FAIL arst_rvalid: got %b/%b expected 00/00", rv_a, rv_b); end
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL arst_rdata: got %h expected 0", rd_a); end
    cyc;
    cyc; rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc; #4;
      checks++; if (rv_a !== 2'b00 || rv_b !== 2'b00) begin errors++; $display("FAIL arst_quiet[%0d]: got %b/%b expected 00/00", k, rv_a, rv_b); end
    end
    cyc; req2 = 2'b11; #4;
    checks++; if (gnt_a !== 2'b01) begin errors++; $display("FAIL arst_first_gnt: got %b expected 01", gnt_a); end
    cyc; req2 = 2'b00;
  endtask

  task automatic test_three;
`ifdef IMEM_ARB_PRIO0_EN
    ec = '{0, 0, 0, 0, 1, 2, 1, 2};
`else
    ec = '{0, 1, 2, 0, 1, 2, 1, 2};
`endif
    do_reset;
    for (int k = 0; k < 8; k++) begin
      cyc; req3 = (k < 4) ? 3'b111 : 3'b110; #4;
      checks++; if (gnt_c !== 3'(1) << ec[k]) begin errors++; $display("FAIL three_gnt[%0d]: got %b expected %b", k, gnt_c, 3'(1) << ec[k]); end
      if (k > 0) begin
        checks++; if (rv_c !== 3'(1) << ec[k-1] || rd_c !== f(32'h1C0 + 32'h100 * ec[k-1])) begin errors++; $display("FAIL three_resp[%0d]: got %b/%h expected core %0d", k, rv_c, rd_c, ec[k-1]); end
      end
    end
    cyc; req3 = 3'b000; #4;
    checks++; if (rv_c !== 3'b100 || en_c !== 1'b0) begin errors++; $display("FAIL three_last: got %b/%b expected 100/0", rv_c, en_c); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_latency3;
    test_flush;
    test_async_reset;
    test_three;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Shares a single instruction memory among the fetch stages of NUM_CORES cores. Each core presents a fetch request (PC); the arbiter grants at most one request per cycle, using round-robin order, and drives the shared memory address. It returns the fetched instruction to the granted core a fixed MEM_LAT cycles later. The block sits between the per-core fetch stages and the instruction memory, and supports per-core flush to squash in-flight fetches on redirect.

## Interface
- NUM_CORES, 2: number of requesting cores (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: instruction width.
- MEM_LAT, 1: cycles from grant to response (1..4); 1 suits a combinational memory.

- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_CORES  per-core fetch request; held until granted.
- addr  input  NUM_CORES*ADDR_W  per-core fetch PC; core i uses bits [i*ADDR_W +: ADDR_W]; stable while req is high.
- flush  input  NUM_CORES  per-core squash of in-flight responses.
- gnt  output  NUM_CORES  one-hot or zero; combinational grant this cycle.
- mem_en  output  1  memory read strobe; equals OR of gnt.
- mem_addr  output  ADDR_W  address of granted core; 0 when no grant.
- mem_rdata  input  DATA_W  memory read data.
- rvalid  output  NUM_CORES  registered, one-hot or zero; response valid for core i.
- rdata  output  DATA_W  registered instruction, broadcast to all cores; qualify with rvalid.

## Operation
- Arbitration is combinational from req and rr_ptr. The winner is the first requesting core at or after rr_ptr, wrapping modulo NUM_CORES.
- On any grant to core g, rr_ptr becomes (g+1) mod NUM_CORES at the clock edge. With no grant, rr_ptr holds.
- A grant completes the request handshake. The core may change addr or drop req in the next cycle.
- A response pipeline of depth MEM_LAT carries {valid, core_id} per stage. Stage 0 loads from the grant.
- In the final stage, mem_rdata is captured into rdata and rvalid[core_id] is set for one cycle.
- flush[i] high in cycle T clears valid for every in-flight entry owned by core i, including a grant to core i issued in T. No rvalid[i] results from those entries. flush does not block arbitration.
- rdata holds its last captured value when no response is valid.
- Throughput is one grant per cycle. With all cores requesting continuously, each core is granted once every NUM_CORES cycles.

## Timing
- Grant in cycle T: mem_addr and mem_en are valid during T. rvalid and rdata are valid in cycle T+MEM_LAT.
- For MEM_LAT>1, the memory must present mem_rdata during cycle T+MEM_LAT-1.
- Reset values: rr_ptr=0, all pipeline valids=0, rvalid=0, rdata=0. gnt, mem_en and mem_addr follow req combinationally, so they are 0 when req=0.
- Reset mid-operation drops all in-flight responses. Requesters must re-issue after reset.
- Back-to-back grants to different cores produce back-to-back rvalid pulses in the same order.
- A single core requesting alone is granted every cycle, regardless of rr_ptr.
- rr_ptr wraps from NUM_CORES-1 to 0.

## Configuration
- IMEM_ARB_PRIO0_EN defined: core 0 has fixed highest priority and wins whenever req[0] is high. Remaining cores arbitrate round-robin among themselves. rr_ptr advances only on grants to cores 1..NUM_CORES-1.
- Not defined: pure round-robin across all cores, as described above.

## Test plan
- Reset, then req=2'b01, addr0=0x100, MEM_LAT=1 -> gnt=01 and mem_addr=0x100 in T; rvalid=01 and rdata=mem[0x100] in T+1.
- req=2'b11 held 6 cycles, NUM_CORES=2 -> gnt alternates 01,10,01,10,01,10; rvalid follows one cycle later in the same order.
- MEM_LAT=3 with grants to core0 in T and core1 in T+1 -> rvalid=01 in T+3 and rvalid=10 in T+4, each with correct data.
- Grant core1 in T, flush[1] in T+1, MEM_LAT=3 -> no rvalid[1] at T+3. A core0 entry in flight at the same time still returns.
- rst asserted asynchronously while 2 responses are in flight -> rvalid=0 immediately and stays 0. rr_ptr=0, so with req=11 after reset, core0 is granted first.
- IMEM_ARB_PRIO0_EN, req=111 for 4 cycles, NUM_CORES=3 -> gnt=001 every cycle. Drop req[0] -> gnt alternates 010,100.
